// File: rtl/onchip_mem_stream_master.sv
// Purpose : bulk mover between a valid/ready stream and a single-port on-chip RAM (read latency 1).
// Latency : write beats hit RAM in the handshake cycle; first read word appears 2 cycles after entering RD.
// Backpres: in_ready stalls the source; read issue throttled so FIFO + in-flight never exceeds 2.
//
// Ports: clk/reset_n (async active-low); cmd_* command handshake (write dir, word addr, len 0..2^ADDR_W);
//        in_* source stream (write mode); out_* sink stream (read mode); busy/done status;
//        avm_* Avalon-MM master to the RAM slave (no waitrequest, readdata valid one cycle after read).

// Small generic FIFO; DEPTH must be a power of two so pointers wrap naturally.
module onchip_mem_stream_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + PTR_ONE;
      if (pop)  rp_q <= rp_q + PTR_ONE;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: cnt gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) mem[wp_q] <= push_data;
  end

  assign head = mem[rp_q];
  assign cnt  = cnt_q;
endmodule

module onchip_mem_stream_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [BE_W-1:0]   avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata
);
  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE  = 1;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              inflight_q;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  logic              wr_beat, rd_issue, pop;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign in_ready  = (state_q == WR) && (rem_q != '0);
  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign wr_beat   = in_valid && in_ready;

  // Occupancy the FIFO would have next cycle if nothing new were issued now;
  // a new read may only go out if its data is guaranteed a slot.
  assign occ      = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (state_q == RD) && (rem_q != '0) && (occ < 3'd2);

  assign avm_chipselect = wr_beat || rd_issue;
  assign avm_write      = wr_beat;
  assign avm_address    = addr_q;
  assign avm_writedata  = wr_beat ? in_data : '0;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;

  onchip_mem_stream_fifo #(.W(DATA_W), .DEPTH(2)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_data (avm_readdata),
    .pop       (pop),
    .head      (out_data),
    .cnt       (fifo_cnt)
  );

  // Direction is carried by the WR/RD state itself, so no separate mode flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
            if (cmd_len == '0)  state_q <= FIN;
            else if (cmd_write) state_q <= WR;
            else                state_q <= RD;
          end
        end
        WR: begin
          if (wr_beat) begin
            addr_q <= addr_q + ADDR_ONE;
            rem_q  <= rem_q - REM_ONE;
            if (rem_q == REM_ONE) state_q <= FIN;
          end
        end
        RD: begin
          if (rd_issue) begin
            addr_q <= addr_q + ADDR_ONE;
            rem_q  <= rem_q - REM_ONE;
          end
          // Finish once every word is issued, returned and popped.
          if ((rem_q == '0) && !inflight_q && (fifo_cnt == {1'b0, pop}))
            state_q <= FIN;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onchip_mem_stream_master.sv
module tb_onchip_mem_stream_master;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic        busy, done;
  logic [9:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write, avm_clken;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;

  always #5 clk = ~clk;

  onchip_mem_stream_master #(.ADDR_W(10), .DATA_W(32), .BE_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_clken(avm_clken),
    .avm_readdata(avm_readdata)
  );

  // RAM slave: writes commit at the edge, read data valid the following cycle.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (avm_chipselect) begin
      if (avm_write) ram[avm_address] <= avm_writedata;
      else           avm_readdata     <= ram[avm_address];
    end
  end

  // Reference model: memory image plus expected transaction queues.
  logic [31:0] ref_mem [1024];
  logic [41:0] exp_wr_q [$];   // {address, data}
  logic [9:0]  exp_ra_q [$];   // read addresses
  logic [31:0] exp_out_q [$];  // stream words
  logic [31:0] wsrc [$];       // optional fixed source data for the next write
  int checks = 0, errors = 0;
  int dones_seen = 0, dones_exp = 0;
  int issued = 0, popped = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compares DUT activity against queued expectations.
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_chipselect) begin
        chk("byteenable", avm_byteenable, 4'hF);
        if (avm_write) begin
          if (exp_wr_q.size() == 0) chk("unexpected_write", {avm_address, avm_writedata}, 0);
          else chk("write_beat", {avm_address, avm_writedata}, exp_wr_q.pop_front());
        end else begin
          issued++;
          if (exp_ra_q.size() == 0) chk("unexpected_read", avm_address, 0);
          else chk("read_addr", avm_address, exp_ra_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        popped++;
        if (exp_out_q.size() == 0) chk("unexpected_out", out_data, 0);
        else chk("out_data", out_data, exp_out_q.pop_front());
      end
      if (avm_chipselect && !avm_write)
        chk("rd_occupancy_le2", (issued - popped) <= 2, 1);
      if (done) dones_seen++;
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_cs"}, avm_chipselect, 0);
    chk({tag, "_wr"}, avm_write, 0);
    chk({tag, "_addr"}, avm_address, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after accept.
  task automatic send_cmd(input logic wr, input int addr, input int len);
    cmd_valid = 1'b1; cmd_write = wr;
    cmd_addr = 10'(addr); cmd_len = 11'(len);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic finish_xfer();
    chk("done_pulse", done, 1);
    chk("queues_drained", exp_wr_q.size() + exp_ra_q.size() + exp_out_q.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  task automatic do_write(input int addr, input int len, input bit rnd);
    logic [31:0] d [$];
    int i, cyc;
    bit hs;
    for (int k = 0; k < len; k++) begin
      logic [31:0] v;
      v = (wsrc.size() != 0) ? wsrc.pop_front() : $urandom;
      d.push_back(v);
      ref_mem[(addr + k) % 1024] = v;
      exp_wr_q.push_back({10'((addr + k) % 1024), v});
    end
    wsrc.delete();
    dones_exp++;
    send_cmd(1'b1, addr, len);
    chk("busy_after_accept", busy, 1);
    if (len != 0) begin
      chk("cmd_ready_busy", cmd_ready, 0);
      i = 0; cyc = 0;
      while (i < len && cyc < 5000) begin
        in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data   = d[i];
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        hs = in_valid && in_ready;
        @(posedge clk); #1;
        if (hs) i++;
        cyc++;
      end
      in_valid = 1'b0;
      chk("write_complete", i, len);
    end
    finish_xfer();
  endtask

  // mode 0: out_ready high; 1: pattern 1,0,0; 2: random. abort_at>0 resets after that many words.
  task automatic do_read(input int addr, input int len, input int mode, input int abort_at);
    int n, cyc, first;
    for (int k = 0; k < len; k++) begin
      exp_ra_q.push_back(10'((addr + k) % 1024));
      exp_out_q.push_back(ref_mem[(addr + k) % 1024]);
    end
    send_cmd(1'b0, addr, len);
    if (len != 0) begin
      n = 0; cyc = 0; first = -1;
      while (n < len && cyc < 5000) begin
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
        @(negedge clk);
        if (out_valid && first < 0) first = cyc;
        if (out_valid && out_ready) n++;
        @(posedge clk); #1;
        cyc++;
        if (abort_at > 0 && n == abort_at) break;
      end
      in_valid = 1'b0;
      if (abort_at > 0) begin
        chk("abort_reached", n, abort_at);
        #2 reset_n = 1'b0;
        #1 check_idle("midreset");
        exp_ra_q.delete(); exp_out_q.delete();
        issued = 0; popped = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("no_done_after_abort", done, 0);
        return;
      end
      chk("read_complete", n, len);
      if (mode == 0) begin
        chk("first_out_latency", first, 2);
        chk("sustained_rate", cyc, len + 2);
      end
    end else begin
      chk("len0_done_next_cycle", done, 1);
    end
    dones_exp++;
    finish_xfer();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      ram[k]     = 32'(k) * 32'h9E3779B1;
      ref_mem[k] = 32'(k) * 32'h9E3779B1;
    end
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check_idle("reset");
    chk("reset_clken", avm_clken, 1);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) wsrc.push_back(32'hA0 + 32'(k));
    do_write(32'h010, 4, 1'b0);
    do_read(32'h010, 4, 0, 0);
    wsrc.push_back(32'h11); wsrc.push_back(32'h22); wsrc.push_back(32'h33);
    do_write(32'h3FE, 3, 1'b0);
    do_read(32'h3FE, 3, 0, 0);
    do_write(32'h100, 8, 1'b1);
    do_read(32'h100, 8, 1, 0);
    do_write(32'h050, 0, 1'b0);
    do_read(32'h050, 0, 0, 0);
    do_read(32'h100, 8, 0, 3);
    do_read(32'h100, 8, 2, 0);

    for (int t = 0; t < 30; t++) begin
      int a, l;
      a = $urandom_range(0, 1023);
      l = $urandom_range(0, 24);
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1'b1);
      else do_read(a, l, $urandom_range(0, 2), 0);
    end
    do_write($urandom_range(0, 1023), 1024, 1'b1);
    do_read($urandom_range(0, 1023), 1024, 2, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", dones_seen, dones_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/onchip_mem_stream_master.md
Name: onchip_mem_stream_master

Overview:
Avalon-MM master that drives the single-port on-chip RAM slave (s1/s2 style: address, byteenable, chipselect, write, writedata, clken, readdata; no waitrequest; fixed read latency 1). It converts a command (direction, base word address, length) plus a streaming data interface into back-to-back RAM accesses. In write mode it fills RAM from a source stream. In read mode it dumps RAM to a sink stream with backpressure. It serves as the bulk data mover between the SPI datapath and on-chip memory, without Nios intervention.

Parameters:
ADDR_W, 10, RAM word-address width (depth 2^ADDR_W = 1024)
DATA_W, 32, RAM data width
BE_W, 4, byteenable width (DATA_W/8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = stream to RAM; 0 = RAM to stream
cmd_addr  in  ADDR_W  start word address
cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W
in_data  in  DATA_W  write-mode source data
in_valid  in  1  source valid
in_ready  out  1  source ready
out_data  out  DATA_W  read-mode sink data
out_valid  out  1  sink valid
out_ready  in  1  sink ready
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
avm_address  out  ADDR_W  RAM address
avm_byteenable  out  BE_W  RAM byte enables, always all ones
avm_chipselect  out  1  RAM select
avm_write  out  1  RAM write strobe
avm_writedata  out  DATA_W  RAM write data
avm_clken  out  1  RAM clock enable, constant 1 out of reset
avm_readdata  in  DATA_W  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (async, reset_n=0): state IDLE; cmd_ready=1, busy=0, done=0, in_ready=0, out_valid=0, avm_chipselect=0, avm_write=0, avm_address=0, out FIFO empty, in-flight count 0. A mid-transfer reset aborts with no done pulse; RAM contents are untouched beyond the beats already written.
- States: IDLE, WR, RD, FIN.
- IDLE: on cmd_valid, latch cmd_addr into addr_q, cmd_len into rem_q and cmd_write. Then go to WR or RD. If cmd_len=0, go to FIN instead with no RAM access. busy = (state != IDLE).
- WR: in_ready = (rem_q != 0).
  - Each in_valid&in_ready cycle: avm_chipselect=avm_write=1, avm_address=addr_q, avm_writedata=in_data, combinationally in the same cycle.
  - addr_q increments mod 2^ADDR_W; rem_q decrements.
  - After the beat that brings rem_q to 0, go to FIN. One word per cycle sustained.
- RD: a read is issued (avm_chipselect=1, avm_write=0, avm_address=addr_q) when rem_q != 0 and (fifo_cnt + inflight - pop) < 2, where pop = out_valid&out_ready.
  - inflight is 1 for the cycle after an issue.
  - avm_readdata is pushed into a 2-entry output FIFO the cycle after the issue.
  - out_data/out_valid come from the FIFO head.
  - Sustained 1 word/cycle when out_ready is held high. First out_valid appears 2 cycles after entering RD.
  - Go to FIN when rem_q=0, inflight=0, and the FIFO is empty after the last pop.
- FIN: done=1 for exactly one cycle, then IDLE.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Address wrap: 0x3FF is followed by 0x000. cmd_len=1024 touches every word exactly once.
- Read order is preserved; no word is dropped or duplicated under any out_ready pattern.
- The memory is never accessed outside WR/RD beats, and at most one access occurs per cycle.
- Changes on in_valid/out_ready while in the wrong mode have no effect.

Test Plan:
- Write cmd addr=0x010 len=4, data 0xA0..0xA3 with in_valid always high -> 4 consecutive write cycles at addresses 0x010..0x013; done 1 cycle after the last beat; cmd_ready returns high.
- Read cmd addr=0x010 len=4, out_ready=1 -> reads on 4 consecutive cycles; out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting 2 cycles after command accept; then done.
- Wrap: write len=3 at 0x3FE with 0x11,0x22,0x33, then read it back -> addresses 0x3FE,0x3FF,0x000; readback matches.
- Backpressure: read len=8 with out_ready toggling 1,0,0,1,... -> fifo_cnt never exceeds 2; all 8 words delivered in order; no read issued while FIFO plus in-flight equals 2.
- len=0 -> no chipselect asserted; done pulses in the cycle after accept.
- Reset_n pulsed low mid-read (after 3 of 8 words) -> all outputs return to reset values asynchronously; no done pulse; a subsequent command executes normally.
